slot_allocator: RTL and testbench

//  Parametrised free-slot allocator; successor to the 8-slot lowest-zero encoder.

---
 rtl/slot_allocator.sv | 132 +++++++++++++
 tb/tb_slot_allocator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_allocator.sv
// Free-slot allocator: occupancy bitmap with one grant and one release per cycle.
// Selection is lowest-free-first (MODE 0) or round-robin from the last grant (MODE 1).
module slot_allocator #(
    parameter int NUM_SLOTS = 32,
    parameter int MODE      = 0,
    localparam int IDX_W    = $clog2(NUM_SLOTS),
    localparam int CNT_W    = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic             alloc_fail,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             rel_vld,
    input  logic [IDX_W-1:0] rel_idx,
    output logic             rel_err,
    output logic [CNT_W-1:0] free_cnt,
    output logic             full,
    output logic             empty
);

    // Bit set = slot occupied.
    logic [NUM_SLOTS-1:0] bitmap_q, bitmap_d;
    logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     alloc_idx_q, alloc_idx_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 alloc_gnt_q, alloc_gnt_d;
    logic                 alloc_fail_q, alloc_fail_d;
    logic                 rel_err_q, rel_err_d;

    logic                 found;
    logic [IDX_W-1:0]     found_idx;
    logic                 rel_in_range;
    logic                 rel_ok;
    logic                 grant;

    // Search always looks at the pre-edge bitmap, so a slot released this
    // cycle cannot be handed out in the same cycle.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            int cand;
            cand = (MODE == 1) ? int'(rr_ptr_q) + i : i;
            if (cand >= NUM_SLOTS) begin
                cand = cand - NUM_SLOTS;
            end
            if (!found && !bitmap_q[IDX_W'(cand)]) begin
                found     = 1'b1;
                found_idx = IDX_W'(cand);
            end
        end
    end

    generate
        if ((2 ** IDX_W) == NUM_SLOTS) begin : g_pow2
            assign rel_in_range = 1'b1;
        end else begin : g_npow2
            assign rel_in_range = (int'(rel_idx) < NUM_SLOTS);
        end
    endgenerate

    assign rel_ok = rel_vld && rel_in_range && bitmap_q[rel_idx];
    assign grant  = alloc_req && found;

    always_comb begin
        bitmap_d     = bitmap_q;
        free_cnt_d   = free_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        alloc_idx_d  = alloc_idx_q;
        alloc_gnt_d  = grant;
        alloc_fail_d = alloc_req && !found;
        rel_err_d    = rel_vld && !rel_ok;

        if (grant) begin
            bitmap_d[found_idx] = 1'b1;
            alloc_idx_d         = found_idx;
            rr_ptr_d            = (found_idx == IDX_W'(NUM_SLOTS - 1)) ? '0
                                                                       : found_idx + IDX_W'(1);
        end
        // A valid release targets an occupied slot and a grant a free one, so
        // the two updates never touch the same bit.
        if (rel_ok) begin
            bitmap_d[rel_idx] = 1'b0;
        end

        case ({grant, rel_ok})
            2'b10:   free_cnt_d = free_cnt_q - CNT_W'(1);
            2'b01:   free_cnt_d = free_cnt_q + CNT_W'(1);
            default: free_cnt_d = free_cnt_q;
        endcase

        full_d  = (free_cnt_d == '0);
        empty_d = (free_cnt_d == CNT_W'(NUM_SLOTS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap_q     <= '0;
            free_cnt_q   <= CNT_W'(NUM_SLOTS);
            rr_ptr_q     <= '0;
            alloc_idx_q  <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            alloc_gnt_q  <= 1'b0;
            alloc_fail_q <= 1'b0;
            rel_err_q    <= 1'b0;
        end else begin
            bitmap_q     <= bitmap_d;
            free_cnt_q   <= free_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            alloc_idx_q  <= alloc_idx_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            alloc_gnt_q  <= alloc_gnt_d;
            alloc_fail_q <= alloc_fail_d;
            rel_err_q    <= rel_err_d;
        end
    end

    assign alloc_gnt  = alloc_gnt_q;
    assign alloc_fail = alloc_fail_q;
    assign alloc_idx  = alloc_idx_q;
    assign rel_err    = rel_err_q;
    assign free_cnt   = free_cnt_q;
    assign full       = full_q;
    assign empty      = empty_q;

endmodule

// File: tb/tb_slot_allocator.sv
// Bench for slot_allocator: a 32-slot lowest-first instance and an 8-slot round-robin instance.
// Expected grant indices are queued when requests are driven and popped when grants appear.
module tb_slot_allocator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-slot, MODE 0
    logic       req0 = 1'b0, rv0 = 1'b0;
    logic [4:0] ri0 = '0;
    logic       gnt0, fail0, err0, full0, empty0;
    logic [4:0] idx0;
    logic [5:0] cnt0;

    // 8-slot, MODE 1
    logic       req1 = 1'b0, rv1 = 1'b0;
    logic [2:0] ri1 = '0;
    logic       gnt1, fail1, err1, full1, empty1;
    logic [2:0] idx1;
    logic [3:0] cnt1;

    int checks = 0;
    int failures = 0;
    logic [4:0] exp_q[$];
    logic [2:0] exp1_q[$];

    slot_allocator #(.NUM_SLOTS(32), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .alloc_req(req0), .alloc_gnt(gnt0), .alloc_fail(fail0),
        .alloc_idx(idx0), .rel_vld(rv0), .rel_idx(ri0), .rel_err(err0),
        .free_cnt(cnt0), .full(full0), .empty(empty0)
    );

    slot_allocator #(.NUM_SLOTS(8), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .alloc_req(req1), .alloc_gnt(gnt1), .alloc_fail(fail1),
        .alloc_idx(idx1), .rel_vld(rv1), .rel_idx(ri1), .rel_err(err1),
        .free_cnt(cnt1), .full(full1), .empty(empty1)
    );

    // Drivers: apply inputs at negedge, sample 1 time unit after the next posedge.
    task automatic cyc0(input logic req, input logic rv, input logic [4:0] ri);
        @(negedge clk);
        req0 = req; rv0 = rv; ri0 = ri;
        @(posedge clk);
        #1;
        req0 = 1'b0; rv0 = 1'b0;
    endtask

    task automatic cyc1(input logic req, input logic rv, input logic [2:0] ri);
        @(negedge clk);
        req1 = req; rv1 = rv; ri1 = ri;
        @(posedge clk);
        #1;
        req1 = 1'b0; rv1 = 1'b0;
    endtask

    task automatic grant0_check(input string name);
        logic [4:0] e;
        e = exp_q.pop_front();
        checks++;
        if (gnt0 !== 1'b1 || idx0 !== e) begin
            failures++;
            $display("FAIL %s: gnt=%b idx=%0d, required gnt=1 idx=%0d", name, gnt0, idx0, e);
        end
    endtask

    task automatic grant1_check(input string name);
        logic [2:0] e;
        e = exp1_q.pop_front();
        checks++;
        if (gnt1 !== 1'b1 || idx1 !== e) begin
            failures++;
            $display("FAIL %s: gnt=%b idx=%0d, required gnt=1 idx=%0d", name, gnt1, idx1, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (cnt0 !== 6'd32 || empty0 !== 1'b1 || full0 !== 1'b0 || gnt0 !== 1'b0 ||
            fail0 !== 1'b0 || err0 !== 1'b0 || idx0 !== 5'd0) begin
            failures++;
            $display("FAIL reset0: cnt=%0d empty=%b full=%b gnt=%b fail=%b err=%b idx=%0d, required 32 1 0 0 0 0 0",
                     cnt0, empty0, full0, gnt0, fail0, err0, idx0);
        end
        checks++;
        if (cnt1 !== 4'd8 || empty1 !== 1'b1 || full1 !== 1'b0 || gnt1 !== 1'b0 || idx1 !== 3'd0) begin
            failures++;
            $display("FAIL reset1: cnt=%0d empty=%b full=%b gnt=%b idx=%0d, required 8 1 0 0 0",
                     cnt1, empty1, full1, gnt1, idx1);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(5'(i));
            cyc0(1'b1, 1'b0, '0);
            grant0_check("fill_grant");
            checks++;
            if (cnt0 !== 6'(31 - i) || empty0 !== 1'b0) begin
                failures++;
                $display("FAIL fill_cnt: cnt=%0d empty=%b, required %0d 0", cnt0, empty0, 31 - i);
            end
        end
        checks++;
        if (full0 !== 1'b1) begin
            failures++;
            $display("FAIL fill_full: full=%b, required 1", full0);
        end
        cyc0(1'b1, 1'b0, '0);
        checks++;
        if (fail0 !== 1'b1 || gnt0 !== 1'b0 || idx0 !== 5'd31 || cnt0 !== 6'd0) begin
            failures++;
            $display("FAIL overflow: fail=%b gnt=%b idx=%0d cnt=%0d, required 1 0 31 0",
                     fail0, gnt0, idx0, cnt0);
        end
        cyc0(1'b0, 1'b0, '0);
        checks++;
        if (fail0 !== 1'b0) begin
            failures++;
            $display("FAIL fail_pulse: fail=%b, required 0", fail0);
        end
    endtask

    task automatic test_release_order();
        cyc0(1'b0, 1'b1, 5'd5);
        checks++;
        if (err0 !== 1'b0 || cnt0 !== 6'd1 || full0 !== 1'b0) begin
            failures++;
            $display("FAIL rel5: err=%b cnt=%0d full=%b, required 0 1 0", err0, cnt0, full0);
        end
        cyc0(1'b0, 1'b1, 5'd2);
        checks++;
        if (cnt0 !== 6'd2) begin
            failures++;
            $display("FAIL rel2: cnt=%0d, required 2", cnt0);
        end
        exp_q.push_back(5'd2);
        cyc0(1'b1, 1'b0, '0);
        grant0_check("regrant_2");
        exp_q.push_back(5'd5);
        cyc0(1'b1, 1'b0, '0);
        grant0_check("regrant_5");
        checks++;
        if (cnt0 !== 6'd0 || full0 !== 1'b1) begin
            failures++;
            $display("FAIL refill: cnt=%0d full=%b, required 0 1", cnt0, full0);
        end
        cyc0(1'b0, 1'b1, 5'd5);
        cyc0(1'b0, 1'b1, 5'd5);
        checks++;
        if (err0 !== 1'b1 || cnt0 !== 6'd1) begin
            failures++;
            $display("FAIL double_rel: err=%b cnt=%0d, required 1 1", err0, cnt0);
        end
        exp_q.push_back(5'd5);
        cyc0(1'b1, 1'b0, '0);
        grant0_check("regrant_5b");
        checks++;
        if (err0 !== 1'b0 || full0 !== 1'b1) begin
            failures++;
            $display("FAIL err_pulse: err=%b full=%b, required 0 1", err0, full0);
        end
    endtask

    task automatic test_simultaneous();
        cyc0(1'b1, 1'b1, 5'd7);
        checks++;
        if (fail0 !== 1'b1 || gnt0 !== 1'b0 || full0 !== 1'b0 || cnt0 !== 6'd1 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL full_alloc_rel: fail=%b gnt=%b full=%b cnt=%0d err=%b, required 1 0 0 1 0",
                     fail0, gnt0, full0, cnt0, err0);
        end
        // Only slot 7 free; release 3 alongside the request must not let 3 win.
        exp_q.push_back(5'd7);
        cyc0(1'b1, 1'b1, 5'd3);
        grant0_check("alloc_rel_grant");
        checks++;
        if (cnt0 !== 6'd1 || full0 !== 1'b0 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL alloc_rel_cnt: cnt=%0d full=%b err=%b, required 1 0 0", cnt0, full0, err0);
        end
        exp_q.push_back(5'd3);
        cyc0(1'b1, 1'b0, '0);
        grant0_check("grant_released_3");
        checks++;
        if (full0 !== 1'b1) begin
            failures++;
            $display("FAIL full_again: full=%b, required 1", full0);
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 3; i++) begin
            exp1_q.push_back(3'(i));
            cyc1(1'b1, 1'b0, '0);
            grant1_check("rr_first");
        end
        cyc1(1'b0, 1'b1, 3'd0);
        checks++;
        if (cnt1 !== 4'd6 || err1 !== 1'b0) begin
            failures++;
            $display("FAIL rr_rel0: cnt=%0d err=%b, required 6 0", cnt1, err1);
        end
        for (int i = 3; i < 8; i++) begin
            exp1_q.push_back(3'(i));
            cyc1(1'b1, 1'b0, '0);
            grant1_check("rr_advance");
        end
        exp1_q.push_back(3'd0);
        cyc1(1'b1, 1'b0, '0);
        grant1_check("rr_wrap");
        checks++;
        if (cnt1 !== 4'd0 || full1 !== 1'b1) begin
            failures++;
            $display("FAIL rr_full: cnt=%0d full=%b, required 0 1", cnt1, full1);
        end
        cyc1(1'b1, 1'b0, '0);
        checks++;
        if (fail1 !== 1'b1 || gnt1 !== 1'b0 || idx1 !== 3'd0) begin
            failures++;
            $display("FAIL rr_overflow: fail=%b gnt=%b idx=%0d, required 1 0 0", fail1, gnt1, idx1);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(5'(i));
            cyc0(1'b1, 1'b0, '0);
            grant0_check("hold20");
        end
        checks++;
        if (cnt0 !== 6'd12) begin
            failures++;
            $display("FAIL hold20_cnt: cnt=%0d, required 12", cnt0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (cnt0 !== 6'd32 || empty0 !== 1'b1 || full0 !== 1'b0 || gnt0 !== 1'b0 || idx0 !== 5'd0) begin
            failures++;
            $display("FAIL async_reset: cnt=%0d empty=%b full=%b gnt=%b idx=%0d, required 32 1 0 0 0",
                     cnt0, empty0, full0, gnt0, idx0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(5'd0);
        cyc0(1'b1, 1'b0, '0);
        grant0_check("post_reset_grant0");
        exp1_q.push_back(3'd0);
        cyc1(1'b1, 1'b0, '0);
        grant1_check("post_reset_grant1");
        checks++;
        if (exp_q.size() != 0 || exp1_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left=%0d/%0d, required 0/0", exp_q.size(), exp1_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release_order();
        test_simultaneous();
        test_round_robin();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
